isa_cycle_engine: RTL and testbench
===================================

ISA_CYCLE_ENGINE -- requirements
Module: isa_cycle_engine

Interface
REQ-001 Parameter T_SETUP, default 2: clocks the address is held valid with BALE before the strobe asserts.
REQ-002 Parameter T_STROBE, default 6: minimum strobe-low clocks.
REQ-003 Parameter T_HOLD, default 1: clocks the address and write data are held after the strobe deasserts.
REQ-004 Parameter TIMEOUT, default 1024: maximum strobe-low clocks before a forced release.
REQ-005 Clock and reset SHALL be one clock, clk, with a synchronous active-high reset, reset.
REQ-006 Ports SHALL be, as name  direction  width  meaning:
  clk  in  1  system clock
  reset  in  1  synchronous active-high reset
  addr_in  in  16  I/O address from the address register
  wdata_in  in  16  write data from the data register
  ctrl_in  in  8  control register: bit0 go, bit1 dir (1 = write), bit2 wide (16-bit); other bits ignored
  isa_sa  out  16  ISA address
  isa_bale  out  1  address latch enable
  isa_sbhe_n  out  1  byte-high enable, active low
  isa_ior_n  out  1  I/O read strobe, active low
  isa_iow_n  out  1  I/O write strobe, active low
  isa_sd_out  out  16  ISA write data
  isa_sd_oe  out  1  SD output enable
  isa_sd_in  in  16  ISA read data
  isa_iochrdy  in  1  asynchronous ready; low extends the strobe
  rdata  out  16  captured read data
  rdata_load  out  1  one-clock pulse; loads rdata into the read side of the data register
  busy  out  1  cycle in progress
  done  out  1  one-clock completion pulse
  timeout_err  out  1  sticky flag: last cycle timed out

Function
REQ-007 A start SHALL be the rising edge of ctrl_in[0], detected against a registered copy; starts arriving while busy is high SHALL be ignored.
REQ-008 On start, the block SHALL latch addr_in, wdata_in, dir and wide; later changes on these inputs SHALL NOT affect the cycle in progress.
REQ-009 The FSM SHALL have states IDLE, ADDR, STROBE, HOLD and DONE.
REQ-010 IDLE -> ADDR SHALL occur on the clock after the start edge is sampled; busy SHALL be high in all states except IDLE.
REQ-011 ADDR SHALL last exactly T_SETUP clocks; isa_sa SHALL be valid and isa_bale high for the whole state.
REQ-012 In STROBE, isa_iow_n (write) or isa_ior_n (read) SHALL be low, never both, and isa_bale SHALL be low.
REQ-013 STROBE -> HOLD SHALL occur when the strobe counter is at least T_STROBE and the synchronized iochrdy is 1, or when the counter reaches TIMEOUT.
REQ-014 isa_iochrdy SHALL pass through a 2-flop synchronizer before use.
REQ-015 On a read, isa_sd_in SHALL be registered on the last STROBE clock and presented on rdata.
REQ-016 For a 16-bit read, rdata SHALL be the full captured word; for an 8-bit read it SHALL be {8'h00, sd[7:0]}.
REQ-017 On a read timeout, rdata SHALL be 16'hFFFF.
REQ-018 rdata_load SHALL pulse in the first HOLD clock, for reads only.
REQ-019 isa_sd_oe SHALL be high from ADDR through HOLD, for writes only.
REQ-020 isa_sd_out SHALL equal the latched wdata whenever isa_sd_oe is high.
REQ-021 isa_sbhe_n SHALL equal ~wide during ADDR, STROBE and HOLD, and 1 otherwise.
REQ-022 HOLD SHALL last T_HOLD clocks with both strobes high and address and data unchanged; the FSM then SHALL enter DONE.
REQ-023 DONE SHALL last one clock, with done = 1, then return to IDLE.
REQ-024 timeout_err SHALL be set on a timeout exit from STROBE and cleared at the next start.
REQ-025 Latency with defaults and iochrdy high: for a start sampled at clock N, done SHALL be high at N+10.

Reset
REQ-026 Reset SHALL take priority over all activity, including mid-cycle; on the next edge the FSM SHALL be in IDLE.
REQ-027 Reset values SHALL be: isa_ior_n = isa_iow_n = isa_sbhe_n = 1; isa_bale = isa_sd_oe = busy = done = rdata_load = timeout_err = 0; rdata = 0; isa_sa = 0; isa_sd_out = 0.
REQ-028 The registered copy of go SHALL reset to 0, so a go held high through reset SHALL NOT start a cycle.

Structure
REQ-029 Package isa_pkg SHALL hold the FSM state encoding, the ctrl bit indices (GO = 0, DIR = 1, WIDE = 2) and the default timing constants.
REQ-030 Sub-module sync_2ff SHALL synchronize iochrdy; it SHALL be reusable for other ISA inputs.
REQ-031 Counter widths SHALL be derived from TIMEOUT using clog2.

Verification
REQ-032 8-bit write: addr 0x0220, wdata 0x00A5, ctrl 0x03 -> BALE high for 2 clocks, iow_n low for 6, sbhe_n = 1, sd_out = 0x00A5, done at N+10.
REQ-033 16-bit read, sd_in = 0xBEEF -> rdata = 0xBEEF, one rdata_load pulse, ior_n low for 6 clocks, iow_n stays 1.
REQ-034 iochrdy held low for 20 clocks during a read -> strobe released 2–3 clocks after iochrdy rises, timeout_err = 0.
REQ-035 iochrdy stuck low -> strobe released after 1024 clocks, rdata = 0xFFFF, timeout_err = 1; the next start clears timeout_err.
REQ-036 Reset asserted in STROBE -> strobes high, busy = 0, no done pulse; a second go edge while busy is ignored, giving exactly one done.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared definitions for the ISA I/O cycle engine: FSM encoding, control
// register bit positions and default bus timing.
package isa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } isa_state_e;

  localparam int unsigned CTRL_GO   = 0;
  localparam int unsigned CTRL_DIR  = 1;
  localparam int unsigned CTRL_WIDE = 2;

  localparam int unsigned DEF_T_SETUP  = 2;
  localparam int unsigned DEF_T_STROBE = 6;
  localparam int unsigned DEF_T_HOLD   = 1;
  localparam int unsigned DEF_TIMEOUT  = 1024;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous ISA bus inputs; width and reset
// value are parameters so it can be reused for other bus signals.
module sync_2ff #(
  parameter int unsigned W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/isa_cycle_engine.sv
// ISA I/O cycle generator: one read or write bus cycle per rising edge of
// the go bit, with BALE setup, iochrdy-extended strobe, hold and timeout.
module isa_cycle_engine
  import isa_pkg::*;
#(
  parameter int unsigned T_SETUP  = DEF_T_SETUP,
  parameter int unsigned T_STROBE = DEF_T_STROBE,
  parameter int unsigned T_HOLD   = DEF_T_HOLD,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr_in,
  input  logic [15:0] wdata_in,
  input  logic [7:0]  ctrl_in,
  output logic [15:0] isa_sa,
  output logic        isa_bale,
  output logic        isa_sbhe_n,
  output logic        isa_ior_n,
  output logic        isa_iow_n,
  output logic [15:0] isa_sd_out,
  output logic        isa_sd_oe,
  input  logic [15:0] isa_sd_in,
  input  logic        isa_iochrdy,
  output logic [15:0] rdata,
  output logic        rdata_load,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [CW-1:0] SETUP_C   = CW'(T_SETUP);
  localparam logic [CW-1:0] STROBE_C  = CW'(T_STROBE);
  localparam logic [CW-1:0] HOLD_C    = CW'(T_HOLD);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  isa_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          go_q, armed_q, start_q;
  logic [15:0]   addr_q, wdata_q, rdata_q;
  logic          dir_q, wide_q;
  logic          rdata_load_q, timeout_err_q;
  logic          rdy_s;
  logic          start_edge, strobe_exit, strobe_tmo, in_cycle;
  logic          unused_ctrl;

  assign unused_ctrl = ^ctrl_in[7:3];

  sync_2ff #(.W(1), .RST_VAL(1'b0)) u_sync_rdy (
    .clk   (clk),
    .reset (reset),
    .d_i   (isa_iochrdy),
    .q_o   (rdy_s)
  );

  // armed_q stays low until go is seen low after reset, so a go level held
  // through reset never looks like a fresh edge.
  assign start_edge = ctrl_in[CTRL_GO] & ~go_q & armed_q & ~start_q
                    & (state_q == ST_IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    strobe_exit = 1'b0;
    strobe_tmo  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_q) begin
          state_d = ST_ADDR;
          cnt_d   = ONE_C;
        end
      end
      ST_ADDR: begin
        if (cnt_q >= SETUP_C) begin
          state_d = ST_STROBE;
          cnt_d   = ONE_C;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      ST_STROBE: begin
        if (cnt_q >= STROBE_C && rdy_s) begin
          strobe_exit = 1'b1;
        end else if (cnt_q >= TIMEOUT_C) begin
          strobe_exit = 1'b1;
          strobe_tmo  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
        if (strobe_exit) begin
          state_d = ST_HOLD;
          cnt_d   = ONE_C;
        end
      end
      ST_HOLD: begin
        if (cnt_q >= HOLD_C) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      go_q          <= 1'b0;
      armed_q       <= 1'b0;
      start_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      dir_q         <= 1'b0;
      wide_q        <= 1'b0;
      rdata_q       <= '0;
      rdata_load_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      go_q         <= ctrl_in[CTRL_GO];
      start_q      <= start_edge;
      rdata_load_q <= strobe_exit & ~dir_q;
      if (!ctrl_in[CTRL_GO]) armed_q <= 1'b1;
      if (start_edge) begin
        addr_q        <= addr_in;
        wdata_q       <= wdata_in;
        dir_q         <= ctrl_in[CTRL_DIR];
        wide_q        <= ctrl_in[CTRL_WIDE];
        timeout_err_q <= 1'b0;
      end
      if (strobe_exit && !dir_q) begin
        if (strobe_tmo)  rdata_q <= 16'hFFFF;
        else if (wide_q) rdata_q <= isa_sd_in;
        else             rdata_q <= {8'h00, isa_sd_in[7:0]};
      end
      if (strobe_tmo) timeout_err_q <= 1'b1;
    end
  end

  assign in_cycle    = (state_q == ST_ADDR) || (state_q == ST_STROBE)
                     || (state_q == ST_HOLD);
  assign isa_sa      = addr_q;
  assign isa_bale    = (state_q == ST_ADDR);
  assign isa_sbhe_n  = in_cycle ? ~wide_q : 1'b1;
  assign isa_ior_n   = ~((state_q == ST_STROBE) & ~dir_q);
  assign isa_iow_n   = ~((state_q == ST_STROBE) & dir_q);
  assign isa_sd_oe   = in_cycle & dir_q;
  assign isa_sd_out  = wdata_q;
  assign rdata       = rdata_q;
  assign rdata_load  = rdata_load_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_isa_cycle_engine.sv
// Directed bench for isa_cycle_engine: a vector table of complete bus cycles
// plus hand-written sequences for iochrdy wait, timeout and reset corners.
module tb_isa_cycle_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr_in, wdata_in, isa_sd_in;
  logic [7:0]  ctrl_in;
  logic        isa_iochrdy;
  logic [15:0] isa_sa, isa_sd_out, rdata;
  logic        isa_bale, isa_sbhe_n, isa_ior_n, isa_iow_n, isa_sd_oe;
  logic        rdata_load, busy, done, timeout_err;

  int checks = 0;
  int errors = 0;

  isa_cycle_engine dut (
    .clk         (clk),
    .reset       (reset),
    .addr_in     (addr_in),
    .wdata_in    (wdata_in),
    .ctrl_in     (ctrl_in),
    .isa_sa      (isa_sa),
    .isa_bale    (isa_bale),
    .isa_sbhe_n  (isa_sbhe_n),
    .isa_ior_n   (isa_ior_n),
    .isa_iow_n   (isa_iow_n),
    .isa_sd_out  (isa_sd_out),
    .isa_sd_oe   (isa_sd_oe),
    .isa_sd_in   (isa_sd_in),
    .isa_iochrdy (isa_iochrdy),
    .rdata       (rdata),
    .rdata_load  (rdata_load),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [7:0]  ctrl;
    logic [15:0] sd_in;
    logic        exp_sbhe_n;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycle(input vec_t v, input string tag);
    int lat, bale_n, ior_low, iow_low, both, bad_sa, bad_sbhe, oe_n, bad_sd;
    int ld_n, busy_n, done_n;
    logic is_write;
    lat = -1; bale_n = 0; ior_low = 0; iow_low = 0; both = 0; bad_sa = 0;
    bad_sbhe = 0; oe_n = 0; bad_sd = 0; ld_n = 0; busy_n = 0; done_n = 0;
    is_write = v.ctrl[1];
    ctrl_in = v.ctrl & 8'hFE; addr_in = v.addr; wdata_in = v.wdata; isa_sd_in = v.sd_in;
    tick();
    ctrl_in = v.ctrl;
    tick();
    // inputs change after the start edge; the cycle must use latched values
    addr_in  = ~v.addr;
    wdata_in = ~v.wdata;
    ctrl_in  = {v.ctrl[7:3], ~v.ctrl[2:1], 1'b1};
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (isa_bale) begin
        bale_n++;
        if (isa_sa !== v.addr) bad_sa++;
      end
      if (!isa_ior_n) ior_low++;
      if (!isa_iow_n) iow_low++;
      if (!isa_ior_n && !isa_iow_n) both++;
      if ((!isa_ior_n || !isa_iow_n) && isa_sbhe_n !== v.exp_sbhe_n) bad_sbhe++;
      if (isa_sd_oe) begin
        oe_n++;
        if (isa_sd_out !== v.wdata) bad_sd++;
      end
      if (rdata_load) ld_n++;
      if (busy) busy_n++;
      if (done) begin
        if (lat < 0) lat = k;
        done_n++;
      end
    end
    check({tag, " latency"}, lat, 10);
    check({tag, " bale_clocks"}, bale_n, 2);
    check({tag, " sa_during_bale"}, bad_sa, 0);
    check({tag, " ior_low_clocks"}, ior_low, is_write ? 0 : 6);
    check({tag, " iow_low_clocks"}, iow_low, is_write ? 6 : 0);
    check({tag, " both_strobes"}, both, 0);
    check({tag, " sbhe_n"}, bad_sbhe, 0);
    check({tag, " sd_oe_clocks"}, oe_n, is_write ? 9 : 0);
    check({tag, " sd_out"}, bad_sd, 0);
    check({tag, " rdata_load_pulses"}, ld_n, is_write ? 0 : 1);
    check({tag, " busy_clocks"}, busy_n, 10);
    check({tag, " done_pulses"}, done_n, 1);
    check({tag, " timeout_err"}, timeout_err, 0);
    if (!is_write) check({tag, " rdata"}, rdata, v.exp_rdata);
    ctrl_in = 8'h00;
    tick();
  endtask

  task automatic wait_done(input int budget, output int k);
    k = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (done) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    int n, cnt, k;
    reset = 1'b1; ctrl_in = 8'h01; addr_in = 16'h1234; wdata_in = 16'h5678;
    isa_sd_in = 16'h0000; isa_iochrdy = 1'b1;
    vecs[0] = '{16'h0220, 16'h00A5, 8'h03, 16'h0000, 1'b1, 16'h0000};
    vecs[1] = '{16'h0300, 16'h1234, 8'h07, 16'h0000, 1'b0, 16'h0000};
    vecs[2] = '{16'h0378, 16'h0000, 8'h05, 16'hBEEF, 1'b0, 16'hBEEF};
    vecs[3] = '{16'h0060, 16'h0000, 8'h01, 16'h12C3, 1'b1, 16'h00C3};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 8'hF7, 16'h0000, 1'b0, 16'h0000};
    vecs[5] = '{16'h0001, 16'h0000, 8'h0D, 16'h8001, 1'b0, 16'h8001};

    // reset values, with go held high through reset
    repeat (3) tick();
    check("rst ior_n", isa_ior_n, 1);
    check("rst iow_n", isa_iow_n, 1);
    check("rst sbhe_n", isa_sbhe_n, 1);
    check("rst bale", isa_bale, 0);
    check("rst sd_oe", isa_sd_oe, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst rdata_load", rdata_load, 0);
    check("rst timeout_err", timeout_err, 0);
    check("rst rdata", rdata, 0);
    check("rst isa_sa", isa_sa, 0);
    check("rst sd_out", isa_sd_out, 0);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (busy || done) n++;
    end
    check("go_held_through_reset", n, 0);
    ctrl_in = 8'h00;
    tick();

    for (int i = 0; i < 6; i++) run_cycle(vecs[i], $sformatf("vec%0d", i));

    // iochrdy held low through the strobe for about 20 clocks
    isa_iochrdy = 1'b0;
    repeat (3) tick();
    isa_sd_in = 16'hCAFE;
    ctrl_in = 8'h05;
    cnt = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (!isa_ior_n) begin
        cnt = i;
        break;
      end
    end
    check("wait strobe_seen", (cnt > 0), 1);
    repeat (19) tick();
    check("wait strobe_extended", isa_ior_n, 0);
    isa_iochrdy = 1'b1;
    cnt = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (isa_ior_n) begin
        cnt = i;
        break;
      end
    end
    check("wait release_2_to_3", (cnt >= 2 && cnt <= 3), 1);
    wait_done(10, k);
    check("wait done_seen", (k > 0), 1);
    check("wait rdata", rdata, 16'hCAFE);
    check("wait timeout_err", timeout_err, 0);
    ctrl_in = 8'h00;
    tick();

    // iochrdy stuck low forces a timeout release
    isa_iochrdy = 1'b0;
    isa_sd_in = 16'h1234;
    repeat (3) tick();
    ctrl_in = 8'h01;
    cnt = 0; k = -1;
    for (int i = 1; i <= 1100; i++) begin
      tick();
      if (!isa_ior_n) cnt++;
      if (done) begin
        k = i;
        break;
      end
    end
    check("tmo done_seen", (k > 0), 1);
    check("tmo strobe_clocks", cnt, 1024);
    check("tmo rdata", rdata, 16'hFFFF);
    check("tmo timeout_err_set", timeout_err, 1);
    isa_iochrdy = 1'b1;
    ctrl_in = 8'h00;
    repeat (3) tick();
    ctrl_in = 8'h03;
    tick();
    check("tmo err_cleared_on_start", timeout_err, 0);
    wait_done(15, k);
    check("tmo next_cycle_done", (k > 0), 1);
    check("tmo err_stays_clear", timeout_err, 0);
    ctrl_in = 8'h00;
    tick();

    // reset asserted in the middle of a write strobe
    ctrl_in = 8'h03;
    cnt = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (!isa_iow_n) begin
        cnt = i;
        break;
      end
    end
    check("midrst strobe_seen", (cnt > 0), 1);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("midrst iow_n", isa_iow_n, 1);
    check("midrst ior_n", isa_ior_n, 1);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done || busy) n++;
    end
    check("midrst no_activity", n, 0);
    ctrl_in = 8'h00;
    tick();

    // second go edge while busy is ignored
    ctrl_in = 8'h05;
    isa_sd_in = 16'h0F0F;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) n++;
      if (i == 4) ctrl_in = 8'h04;
      if (i == 5) ctrl_in = 8'h05;
    end
    check("dblgo done_count", n, 1);
    check("dblgo rdata", rdata, 16'h0F0F);
    ctrl_in = 8'h00;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
